dram_responder: RTL
===================

# dram_responder

Memory-side responder for the core's load/store data port. It sits opposite the Mem stage on the request/grant interface. It accepts one request at a time from the LSU, performs a byte, halfword or word read or write on an internal word-organised array after a fixed programmable latency, and returns a one-cycle completion pulse carrying load data or a misalignment error. It replaces the zero-latency data memory so the pipeline can be exercised against realistic memory wait states.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; power of two, at least 4.
- LATENCY, 2, cycles spent in BUSY before the response; legal range 1 to 15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_en  in  1  responder enable; while low, no new request is accepted.
- data_req_ip  in  1  request valid from the LSU.
- data_we_ip  in  1  1 = store, 0 = load.
- data_size_ip  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as misaligned).
- data_addr_ip  in  32  byte address.
- wdata_ip  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- mem_gnt_op  out  1  responder ready; a request is accepted on a rising edge where mem_gnt_op and data_req_ip are both 1.
- resp_valid_op  out  1  one-cycle completion pulse, for loads and for stores.
- load_data_op  out  32  load result, zero-extended and right-aligned; 0 for stores and errors.
- misaligned_err_op  out  1  qualifies resp_valid_op; the access was not performed.

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- IDLE:
  - mem_gnt_op = mem_en.
  - On acceptance, capture addr, we, size and wdata into holding registers, load the latency counter with LATENCY-1, and go to BUSY.
  - Inputs after the acceptance edge are ignored until the FSM returns to IDLE.
- BUSY:
  - mem_gnt_op = 0.
  - The counter decrements each cycle.
  - When the counter reads 0, the access is performed on that edge using the held values, and the FSM goes to RESP.
- RESP:
  - resp_valid_op = 1 for exactly one cycle, with load_data_op and misaligned_err_op valid alongside it.
  - Next state is IDLE.
- Index and wrap-around: word index = addr[log2(DEPTH_WORDS)+1 : 2]. Higher address bits are ignored, so addresses alias modulo 4*DEPTH_WORDS.
- Lane select: byte lane = addr[1:0]; half lane = addr[1].
- Misalignment:
  - Condition: half with addr[0]=1, word with addr[1:0]!=00, or size=11.
  - Effect: no array write, load_data_op = 0, misaligned_err_op = 1.
- Stores are read-modify-write and touch only the addressed lanes; the other bytes of the word are preserved.
- Loads extract the addressed lane into the low bits and zero the upper bits. Sign extension is done by the LSU, not here.
- mem_en low during BUSY or RESP does not abort the transaction; it completes normally. mem_en only gates acceptance.
- Reset asserted (reset=0):
  - The FSM goes to IDLE immediately.
  - All outputs go to 0: mem_gnt_op, resp_valid_op, load_data_op, misaligned_err_op.
  - Holding registers and the counter clear.
  - An in-flight store is dropped.
  - Array contents are not reset.
- A request held high across RESP is not re-accepted until the first IDLE cycle.

## Timing
- Acceptance edge = T.
- BUSY occupies cycles T+1 through T+LATENCY.
- resp_valid_op is high in cycle T+LATENCY+1.
- mem_gnt_op returns high in cycle T+LATENCY+2, if mem_en=1.
- The earliest next acceptance is the edge ending cycle T+LATENCY+2.
- Throughput is therefore one transaction per LATENCY+2 cycles.
- A store's effect becomes visible to any load accepted after its RESP.
- All outputs are registered. None depends combinationally on the inputs, except mem_gnt_op on mem_en in IDLE.

## Test plan
- Reset: hold reset=0 for 3 cycles, then release with mem_en=1 -> all outputs 0 during reset; mem_gnt_op=1 on the first cycle after release.
- Word round trip, LATENCY=2:
  - Store word 0xDEADBEEF to 0x40, accepted at T -> resp_valid_op high exactly at T+3, with load_data_op=0 and misaligned_err_op=0.
  - Load word 0x40 -> load_data_op=0xDEADBEEF.
- Lane merge:
  - Store word 0x11223344 to 0x80, then store byte 0xAA to 0x82 and half 0xBBCC to 0x80.
  - Word load of 0x80 -> 0x11AABBCC.
  - Byte load of 0x83 -> 0x00000011.
- Misalignment:
  - Word store to 0x81 -> misaligned_err_op=1 with resp_valid_op, and the word at 0x80 is unchanged.
  - Half load of 0x83 -> error, load_data_op=0.
- Wrap and back-to-back, DEPTH_WORDS=256:
  - Store 0x5A5A5A5A to 0x400 -> a load of 0x000 returns 0x5A5A5A5A.
  - With data_req_ip held high continuously, consecutive resp_valid_op pulses are exactly 4 cycles apart.
- Reset mid-operation:
  - Accept a store of 0x12345678 to 0x10 (previously 0), then assert reset during BUSY.
  - Expect no resp_valid_op pulse, and a subsequent load of 0x10 returns 0.
  - Separately, drop mem_en during BUSY -> the response still arrives on time and mem_gnt_op stays 0 afterward.

Source files
------------

// File: rtl/dram_responder.sv
// -----------------------------------------------------------------------------
// dram_responder
//
// Memory-side responder for the LSU data port. Accepts one request at a time,
// waits LATENCY cycles in BUSY, performs a byte/half/word access on an
// internal word-organised array, then pulses resp_valid_op for one cycle with
// the load data or a misalignment error.
//
// Ports
//   clock              system clock, rising edge
//   reset              asynchronous, active-low reset
//   mem_en             gates acceptance of new requests only
//   data_req_ip        request valid
//   data_we_ip         1 = store, 0 = load
//   data_size_ip       00 byte, 01 half, 10 word, 11 reserved (error)
//   data_addr_ip       byte address (aliases modulo 4*DEPTH_WORDS)
//   wdata_ip           right-aligned store data
//   mem_gnt_op         ready; request accepted when gnt & req on a rising edge
//   resp_valid_op      one-cycle completion pulse
//   load_data_op       zero-extended, right-aligned load data (0 otherwise)
//   misaligned_err_op  access rejected; qualifies resp_valid_op
// -----------------------------------------------------------------------------
module dram_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        data_req_ip,
    input  logic        data_we_ip,
    input  logic [1:0]  data_size_ip,
    input  logic [31:0] data_addr_ip,
    input  logic [31:0] wdata_ip,
    output logic        mem_gnt_op,
    output logic        resp_valid_op,
    output logic [31:0] load_data_op,
    output logic        misaligned_err_op
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [AW+1:0]   r_addr;
    logic [31:0]     r_wdata;
    logic            r_we;
    logic [1:0]      r_size;
    logic            r_err;

    logic            w_accept;
    logic            w_access;
    logic            w_misal;
    logic            w_wr_en;
    logic            w_rd_en;
    logic [AW-1:0]   w_idx;
    logic [3:0]      w_lane_we;
    logic [31:0]     w_wdata_rep;
    logic [31:0]     w_rd_word;
    logic [31:0]     w_rd_shift;
    logic [31:0]     w_load_val;
    logic            w_unused_addr;

    // Address bits above the array span are deliberately ignored (aliasing).
    assign w_unused_addr = ^data_addr_ip[31:AW+2];

    assign w_accept = (r_state == IDLE) && mem_en && data_req_ip;
    assign w_access = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_idx    = r_addr[AW+1:2];

    // Reset is folded in so the in-flight store cannot land while reset is low.
    assign w_wr_en  = w_access && r_we && !w_misal && reset;
    assign w_rd_en  = w_access && !r_we && !w_misal;

    always_comb begin
        w_misal = 1'b0;
        case (r_size)
            2'b00:   w_misal = 1'b0;
            2'b01:   w_misal = r_addr[0];
            2'b10:   w_misal = |r_addr[1:0];
            default: w_misal = 1'b1;
        endcase
    end

    // Store data is replicated across lanes; the lane enables pick which bytes
    // actually land, so untouched bytes keep their old value without a read.
    always_comb begin
        w_lane_we   = 4'b0000;
        w_wdata_rep = r_wdata;
        case (r_size)
            2'b00: begin
                w_lane_we   = 4'b0001 << r_addr[1:0];
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_lane_we   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                w_lane_we   = 4'b1111;
                w_wdata_rep = r_wdata;
            end
            default: begin
                w_lane_we   = 4'b0000;
                w_wdata_rep = r_wdata;
            end
        endcase
    end

    // One byte-wide array per lane, registered read; contents are not reset.
    for (genvar gi = 0; gi < 4; gi++) begin : gen_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_rd_byte;

        always_ff @(posedge clock) begin
            if (w_wr_en && w_lane_we[gi]) begin
                r_mem[w_idx] <= w_wdata_rep[gi*8 +: 8];
            end
            if (w_rd_en) begin
                r_rd_byte <= r_mem[w_idx];
            end
        end

        assign w_rd_word[gi*8 +: 8] = r_rd_byte;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr  <= data_addr_ip[AW+1:0];
                        r_wdata <= wdata_ip;
                        r_we    <= data_we_ip;
                        r_size  <= data_size_ip;
                        r_cnt   <= CNT_INIT;
                        r_err   <= 1'b0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_err   <= w_misal;
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Lane extraction from the word captured on the access edge.
    assign w_rd_shift = w_rd_word >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load_val = 32'd0;
        case (r_size)
            2'b00:   w_load_val = {24'd0, w_rd_shift[7:0]};
            2'b01:   w_load_val = {16'd0, (r_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0])};
            2'b10:   w_load_val = w_rd_word;
            default: w_load_val = 32'd0;
        endcase
    end

    // Grant follows mem_en only in IDLE and is forced low while reset is held.
    assign mem_gnt_op        = (r_state == IDLE) && mem_en && reset;
    assign resp_valid_op     = (r_state == RESP);
    assign misaligned_err_op = (r_state == RESP) && r_err;
    assign load_data_op      = ((r_state == RESP) && !r_err && !r_we) ? w_load_val : 32'd0;

endmodule
